// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a two-entry skid buffer; 1-cycle latency, full throughput.
// in_ready_o comes from state only, so it drops one cycle after the skid entry fills.
module pipe_skid_stage #(
  parameter int                DATA_W      = 96,
  parameter int                CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [CTRL_W-1:0]      in_ctrl_i,
  input  logic [DATA_W-1:0]      in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [CTRL_W-1:0]      out_ctrl_o,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [CTRL_W-1:0]        main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]        main_data_q, main_data_d;
  logic [CTRL_W-1:0]        skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]        skid_data_q, skid_data_d;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                     in_xfer, out_xfer;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      main_ctrl_q <= CTRL_BUBBLE;
      main_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    in_xfer     = in_valid_i & in_ready_o;
    out_xfer    = out_valid_o & out_ready_i;
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      // Data registers keep their contents; only the ctrl bundle is bubbled.
      state_d     = EMPTY;
      main_ctrl_d = CTRL_BUBBLE;
      skid_ctrl_d = CTRL_BUBBLE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d     = FULL;
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end else if (in_xfer) begin
            state_d     = SKID;
            skid_ctrl_d = in_ctrl_i;
            skid_data_d = in_data_i;
          end
        end
        SKID: begin
          if (out_xfer) begin
            state_d     = FULL;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    out_valid_o = (state_q != EMPTY);
    in_ready_o  = (state_q != SKID);
    out_ctrl_o  = (state_q != EMPTY) ? main_ctrl_q : CTRL_BUBBLE;
    out_data_o  = main_data_q;
    stall_cnt_o = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, hand-written corner sequences,
// and a randomized run against a two-slot FIFO reference model.
module tb_pipe_skid_stage;
  localparam int                DW  = 96;
  localparam int                CW  = 8;
  localparam int                SW  = 4;
  localparam logic [CW-1:0]     BUB = 8'hA5;
  localparam int                CMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [CW-1:0] in_ctrl_i, out_ctrl_o;
  logic [DW-1:0] in_data_i, out_data_o;
  logic [SW-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .STALL_CNT_W(SW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
    .stall_cnt_o(stall_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          v, r, f;
    logic [DW-1:0] d;
    logic          ev, er;
    logic [DW-1:0] ed;
    int            ecnt;
  } vec_t;
  vec_t tbl[10];

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t mq[$];
  int   mcnt;

  function automatic logic [CW-1:0] ctl_of(input logic [DW-1:0] d);
    return d[CW-1:0] ^ 8'h3C;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic er,
                         input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                         input int ecnt, input logic cmp_data);
    chk({tag, ".valid"}, DW'(out_valid_o), DW'(ev));
    chk({tag, ".ready"}, DW'(in_ready_o), DW'(er));
    chk({tag, ".ctrl"},  DW'(out_ctrl_o), DW'(ec));
    chk({tag, ".cnt"},   DW'(stall_cnt_o), DW'(ecnt));
    if (cmp_data) chk({tag, ".data"}, out_data_o, ed);
  endtask

  task automatic drive(input logic v, input logic r, input logic f, input logic rs,
                       input logic [DW-1:0] d);
    in_valid_i  = v;
    out_ready_i = r;
    flush_i     = f;
    rst_i       = rs;
    in_data_i   = d;
    in_ctrl_i   = ctl_of(d);
  endtask

  // Reference: the stage is a FIFO of capacity two whose head is shown downstream.
  task automatic model_step();
    logic ox, ix;
    if (rst_i) begin
      mq.delete();
      mcnt = 0;
    end else begin
      ox = (mq.size() > 0) && out_ready_i;
      ix = (mq.size() < 2) && in_valid_i;
      if ((mq.size() > 0) && !out_ready_i && (mcnt < CMAX)) mcnt++;
      if (flush_i) mq.delete();
      else begin
        if (ox) void'(mq.pop_front());
        if (ix) mq.push_back({in_ctrl_i, in_data_i});
      end
    end
  endtask

  task automatic model_check();
    if (mq.size() > 0) chk_out("rnd", 1'b1, mq.size() < 2, mq[0].c, mq[0].d, mcnt, 1'b1);
    else               chk_out("rnd", 1'b0, 1'b1, BUB, '0, mcnt, 1'b0);
  endtask

  initial begin
    // Skid fill / drain, then flush with two held entries (starts EMPTY, count 0).
    tbl[0] = '{1, 0, 0, 96'hA, 1, 1, 96'hA, 0};
    tbl[1] = '{1, 0, 0, 96'hB, 1, 0, 96'hA, 1};
    tbl[2] = '{1, 0, 0, 96'hC, 1, 0, 96'hA, 2};
    tbl[3] = '{1, 1, 0, 96'hC, 1, 1, 96'hB, 2};
    tbl[4] = '{1, 1, 0, 96'hC, 1, 1, 96'hC, 2};
    tbl[5] = '{0, 1, 0, 96'h0, 0, 1, 96'h0, 2};
    tbl[6] = '{1, 0, 0, 96'hD, 1, 1, 96'hD, 2};
    tbl[7] = '{1, 0, 0, 96'hE, 1, 0, 96'hD, 3};
    tbl[8] = '{1, 0, 1, 96'hF, 0, 1, 96'h0, 4};
    tbl[9] = '{0, 1, 0, 96'h0, 0, 1, 96'h0, 4};

    drive(0, 0, 0, 1, '0);
    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 0, 1, BUB, '0, 0, 1'b1);

    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, 0, DW'(i));
      @(negedge clk);
      chk_out("stream", 1, 1, ctl_of(DW'(i)), DW'(i), 0, 1'b1);
    end
    drive(0, 1, 0, 0, '0);
    @(negedge clk);
    chk_out("stream_end", 0, 1, BUB, '0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].f, 0, tbl[i].d);
      @(negedge clk);
      chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].er,
              tbl[i].ev ? ctl_of(tbl[i].ed) : BUB, tbl[i].ed, tbl[i].ecnt, tbl[i].ev);
    end

    // Saturation: counter continues from 4 and must stick at all-ones.
    drive(1, 0, 0, 0, 96'h55);
    @(negedge clk);
    chk_out("sat_load", 1, 1, ctl_of(96'h55), 96'h55, 4, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 0, '0);
      @(negedge clk);
      chk("sat_cnt", DW'(stall_cnt_o), DW'((4 + k > CMAX) ? CMAX : 4 + k));
    end
    drive(0, 0, 1, 0, '0);
    @(negedge clk);
    chk_out("sat_flush", 0, 1, BUB, '0, CMAX, 1'b0);
    drive(0, 0, 0, 1, '0);
    @(negedge clk);
    chk_out("sat_reset", 0, 1, BUB, '0, 0, 1'b1);

    // Reset together with flush while two entries are held.
    drive(1, 0, 0, 0, 96'h66);
    @(negedge clk);
    drive(1, 0, 0, 0, 96'h67);
    @(negedge clk);
    chk_out("mid_skid", 1, 0, ctl_of(96'h66), 96'h66, 1, 1'b1);
    drive(1, 0, 1, 1, 96'h68);
    @(negedge clk);
    chk_out("mid_reset", 0, 1, BUB, '0, 0, 1'b1);
    drive(1, 1, 0, 0, 96'h77);
    @(negedge clk);
    chk_out("mid_after", 1, 1, ctl_of(96'h77), 96'h77, 0, 1'b1);
    drive(0, 1, 0, 0, '0);
    @(negedge clk);
    chk_out("mid_drain", 0, 1, BUB, '0, 0, 1'b0);

    mq.delete();
    mcnt = 0;
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
            $urandom_range(0, 49) == 0, $urandom_range(0, 999) == 0,
            {$urandom, $urandom, $urandom});
      in_ctrl_i = CW'($urandom);
      model_step();
      @(negedge clk);
      model_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
